melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12_500_000; clock cycles per duration unit (>=2).
REQ-002 SHALL have parameter ADDR_W, default 8; width of the melody ROM address.
REQ-003 SHALL have parameter NOTE_W, default 6; width of the note code.
REQ-004 SHALL have parameter DUR_W, default 4; width of the duration field, in duration units.
REQ-005 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port play  input  1  play/pause level from the play/pause FSM; 1 = play.
REQ-008 SHALL have port restart  input  1  synchronous one-cycle pulse; return to song start.
REQ-009 SHALL have port last_addr  input  ADDR_W  address of the final ROM entry of the song.
REQ-010 SHALL have port rom_addr  output  ADDR_W  melody ROM read address.
REQ-011 SHALL have port rom_note  input  NOTE_W  ROM note data, valid 1 cycle after rom_addr.
REQ-012 SHALL have port rom_dur  input  DUR_W  ROM duration data, valid 1 cycle after rom_addr; 0 = end-of-song marker.
REQ-013 SHALL have port note_out  output  NOTE_W  current note code for the tone generator.
REQ-014 SHALL have port note_valid  output  1  1 exactly while a note sounds (state PLAY).
REQ-015 SHALL have port song_end  output  1  one-cycle pulse when the song wraps to address 0.

Function
REQ-016 SHALL implement states IDLE, FETCH, LOAD, PLAY, PAUSE, END.
REQ-017 IDLE: rom_addr=0, note_valid=0; play=1 -> FETCH.
REQ-018 FETCH: one cycle; rom_addr held; always -> LOAD (covers the 1-cycle ROM latency).
REQ-019 LOAD: note_out<=rom_note, dur_cnt<=rom_dur, prescaler cleared. If rom_dur=0 -> END; else if play=1 -> PLAY; else -> PAUSE.
REQ-020 PLAY: prescaler counts 0..TICK_DIV-1 and wraps; tick asserts on count TICK_DIV-1; each tick decrements dur_cnt.
REQ-021 PLAY: a tick with dur_cnt=1 SHALL end the note. If rom_addr=last_addr, rom_addr<=0 and song_end pulses; else rom_addr<=rom_addr+1. Next state -> FETCH.
REQ-022 Each note SHALL hold note_valid=1 for exactly rom_dur*TICK_DIV cycles, followed by a 2-cycle gap (FETCH, LOAD) with note_valid=0.
REQ-023 PLAY with play=0 -> PAUSE; prescaler, dur_cnt, note_out and rom_addr frozen; note_valid=0.
REQ-024 PAUSE with play=1 -> PLAY, resuming the prescaler from its frozen value; total sounding cycles per note unchanged.
REQ-025 When play falls during FETCH, LOAD completes normally and the next state is PAUSE.
REQ-026 If play falls on the cycle of a note-ending tick, the note-end action wins and the following LOAD enters PAUSE.
REQ-027 END: one cycle; rom_addr<=0, song_end=1; play=1 -> FETCH, else -> IDLE.
REQ-028 restart=1 SHALL override every state transition: rom_addr<=0, prescaler<=0, dur_cnt<=0, note_valid=0, no song_end pulse; next state FETCH if play=1, else IDLE.
REQ-029 rom_addr increment SHALL be modulo 2^ADDR_W; with last_addr=2^ADDR_W-1 it wraps naturally to 0 with song_end.
REQ-030 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-031 While reset=0, asynchronously: state=IDLE, rom_addr=0, note_out=0, note_valid=0, song_end=0, dur_cnt=0, prescaler=0.
REQ-032 Reset asserted mid-note SHALL abort the note immediately; after release, the song restarts at address 0 when play=1.

Structure
REQ-033 A shared package melody_pkg SHALL hold the state encoding constants and the default TICK_DIV, ADDR_W, NOTE_W and DUR_W values.
REQ-034 The prescaler SHALL be a sub-module tick_divider (ports: clk, reset, en, clr, tick).

Verification (TICK_DIV=4; ROM: a0={note 5, dur 2}, a1={note 9, dur 1}, a2={dur 0}; last_addr=7)
REQ-035 play=1 from IDLE -> note_out=5 with note_valid=1 for 8 cycles, 2-cycle gap, note_out=9 for 4 cycles, then END with song_end for 1 cycle and rom_addr=0.
REQ-036 Drop play for 10 cycles after 3 cycles of note 5 -> note_valid=0 for those 10 cycles; after play returns, note 5 sounds 5 more cycles.
REQ-037 Pulse restart while note 9 sounds -> note_valid=0 next cycle, rom_addr=0, then note 5 replays after FETCH/LOAD; no song_end pulse.
REQ-038 Set last_addr=1 -> after note 9, rom_addr wraps to 0 with song_end=1; a2 is never fetched.
REQ-039 Assert reset=0 mid-note 5 -> all outputs 0 asynchronously; release with play=1 -> sequence restarts from a0.
REQ-040 Drop play on the exact cycle of the final tick of note 5 -> rom_addr=1 and LOAD captures note 9, then PAUSE with note_valid=0.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared state encoding and default sizing for the melody sequencer.
package melody_pkg;

  localparam int DEF_TICK_DIV = 12_500_000;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_NOTE_W   = 6;
  localparam int DEF_DUR_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_END   = 3'd5
  } state_t;

endpackage

// File: rtl/tick_divider.sv
// Duration prescaler: counts enabled cycles 0..TICK_DIV-1, flags the last one as tick.
// The count freezes while en is low; clr has priority over en.
module tick_divider #(
  parameter int TICK_DIV = melody_pkg::DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a melody ROM, holding each note for rom_dur prescaler ticks.
// play pauses without losing position; restart and the end marker return to address 0.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NOTE_W   = DEF_NOTE_W,
  parameter int DUR_W    = DEF_DUR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              restart,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              song_end
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              song_end_q, song_end_d;
  logic              presc_en, presc_clr, tick;

  // The prescaler runs on every PLAY cycle, including the one where play drops,
  // so each PLAY cycle counts exactly once toward the note length.
  assign presc_en = (state_q == ST_PLAY);

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk  (clk),
    .reset(reset),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    note_d     = note_q;
    dur_d      = dur_q;
    song_end_d = 1'b0;
    presc_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (play) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        note_d    = rom_note;
        dur_d     = rom_dur;
        presc_clr = 1'b1;
        if (rom_dur == '0) begin
          state_d    = ST_END;
          addr_d     = '0;
          song_end_d = 1'b1;
        end else if (play) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_PLAY: begin
        if (tick) dur_d = dur_q - DUR_W'(1);
        // A note-ending tick wins over a simultaneous pause request.
        if (tick && (dur_q == DUR_W'(1))) begin
          state_d = ST_FETCH;
          if (addr_q == last_addr) begin
            addr_d     = '0;
            song_end_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else if (!play) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (play) state_d = ST_PLAY;
      end
      ST_END: begin
        addr_d  = '0;
        state_d = play ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d    = play ? ST_FETCH : ST_IDLE;
      addr_d     = '0;
      note_d     = note_q;
      dur_d      = '0;
      song_end_d = 1'b0;
      presc_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      note_q     <= '0;
      dur_q      <= '0;
      song_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      song_end_q <= song_end_d;
    end
  end

  assign rom_addr   = addr_q;
  assign note_out   = note_q;
  assign note_valid = (state_q == ST_PLAY);
  assign song_end   = song_end_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: a song-walk model predicts note/wrap events, a monitor consumes them.
module tb_melody_sequencer;

  localparam int TD    = 4;
  localparam int AW    = 3;
  localparam int NW    = 6;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int K_NOTE = 0;
  localparam int K_SEND = 1;

  typedef struct {
    int kind;
    int note;
    int cyc;
    int addr;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          play = 1'b0;
  logic          restart = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] rom_addr;
  logic [NW-1:0] rom_note = '0;
  logic [DW-1:0] rom_dur = '0;
  logic [NW-1:0] note_out;
  logic          note_valid;
  logic          song_end;

  logic [NW-1:0] rom_n [DEPTH];
  logic [DW-1:0] rom_d [DEPTH];

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  bit  flush_req = 1'b0;

  melody_sequencer #(
    .TICK_DIV(TD), .ADDR_W(AW), .NOTE_W(NW), .DUR_W(DW)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .play      (play),
    .restart   (restart),
    .last_addr (last_addr),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .rom_dur   (rom_dur),
    .note_out  (note_out),
    .note_valid(note_valid),
    .song_end  (song_end)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) begin
    rom_note <= rom_n[rom_addr];
    rom_dur  <= rom_d[rom_addr];
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic pop_check(input int kind, input int note, input int cyc, input int addr);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_output: kind=%0d note=%0d cycles=%0d addr=%0d, nothing expected",
               kind, note, cyc, addr);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.note != note || e.cyc != cyc || e.addr != addr) begin
      n_fail++;
      $display("FAIL scoreboard: got kind=%0d note=%0d cycles=%0d addr=%0d, expected kind=%0d note=%0d cycles=%0d addr=%0d",
               kind, note, cyc, addr, e.kind, e.note, e.cyc, e.addr);
    end
  endtask

  task automatic push_note(input int note, input int cyc, input int nxt);
    ev_t e;
    e = '{K_NOTE, note, cyc, nxt};
    exp_q.push_back(e);
  endtask

  task automatic push_send();
    ev_t e;
    e = '{K_SEND, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  // Reference model: walk the song from address 0 for a number of ROM steps.
  task automatic push_walk(input int steps);
    int a;
    int nxt;
    a = 0;
    for (int s = 0; s < steps; s++) begin
      if (rom_d[a] == 0) begin
        push_send();
        a = 0;
      end else begin
        nxt = (a == int'(last_addr)) ? 0 : (a + 1) % DEPTH;
        push_note(int'(rom_n[a]), int'(rom_d[a]) * TD, nxt);
        if (a == int'(last_addr)) push_send();
        a = nxt;
      end
    end
  endtask

  // Monitor: a note completes when sounding stops and rom_addr has moved on.
  int acc = 0;
  int cur_note = 0;
  int gap_cnt = 0;
  int prev_addr = 0;
  bit gap_chk = 1'b0;
  bit prev_valid = 1'b0;
  bit play_smp = 1'b0;
  bit completed;

  always @(posedge clk) begin
    play_smp = play;
    #1;
    if (!rst_n || flush_req) begin
      acc        = 0;
      prev_valid = 1'b0;
      prev_addr  = int'(rom_addr);
      gap_chk    = 1'b0;
      flush_req  = 1'b0;
    end else begin
      completed = 1'b0;
      if (!play_smp) begin
        chk("valid_low_while_play_low", int'(note_valid), 0);
        gap_chk = 1'b0;
      end
      if (note_valid) begin
        if (gap_chk) begin
          chk("inter_note_gap", gap_cnt, 2);
          gap_chk = 1'b0;
        end
        acc++;
        cur_note = int'(note_out);
      end else if (prev_valid && int'(rom_addr) != prev_addr) begin
        pop_check(K_NOTE, cur_note, acc, int'(rom_addr));
        acc       = 0;
        completed = 1'b1;
        gap_chk   = play_smp;
        gap_cnt   = 1;
      end else begin
        gap_cnt++;
      end
      if (song_end) begin
        pop_check(K_SEND, 0, 0, int'(rom_addr));
        if (!completed) gap_chk = 1'b0;
      end
      prev_valid = note_valid;
      prev_addr  = int'(rom_addr);
    end
  end

  task automatic wait_drain(input string name, input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      if (rnd) play = ($urandom_range(0, 99) < 70);
      n++;
    end
    chk({name, "_pending_outputs"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_valid(input string name, input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (note_valid) seen++;
    end
    chk(name, seen, n);
  endtask

  // Called at a negedge: return the DUT to IDLE at address 0.
  task automatic stop_song();
    play      = 1'b0;
    restart   = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("stop_note_valid", int'(note_valid), 0);
    chk("stop_rom_addr", int'(rom_addr), 0);
  endtask

  task automatic load_spec_rom();
    for (int i = 0; i < DEPTH; i++) begin
      rom_n[i] = '0;
      rom_d[i] = '0;
    end
    rom_n[0] = NW'(5);
    rom_d[0] = DW'(2);
    rom_n[1] = NW'(9);
    rom_d[1] = DW'(1);
    rom_n[2] = NW'(3);
    rom_d[2] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    load_spec_rom();
    last_addr = AW'(7);
    repeat (2) @(negedge clk);
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_note_out", int'(note_out), 0);
    chk("reset_note_valid", int'(note_valid), 0);
    chk("reset_song_end", int'(song_end), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rom_addr", int'(rom_addr), 0);
    chk("idle_note_valid", int'(note_valid), 0);

    // Basic song: 5 for 8 cycles, 9 for 4 cycles, end marker.
    push_walk(3);
    play = 1'b1;
    wait_drain("basic_song", 100, 1'b0);
    stop_song();

    // Pause after three cycles of note 5 for ten cycles.
    push_walk(3);
    play = 1'b1;
    wait_valid("pause_lead_in", 3);
    play = 1'b0;
    repeat (10) @(negedge clk);
    play = 1'b1;
    wait_drain("pause_resume", 200, 1'b0);
    stop_song();

    // Restart while note 9 sounds.
    push_note(5, 8, 1);
    play = 1'b1;
    wait_valid("restart_lead_in", 10);
    chk("restart_pre_note", int'(note_out), 9);
    restart   = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_note_valid", int'(note_valid), 0);
    chk("restart_rom_addr", int'(rom_addr), 0);
    chk("restart_song_end", int'(song_end), 0);
    push_walk(3);
    wait_drain("restart_replay", 100, 1'b0);
    stop_song();

    // last_addr=1 wraps after note 9; a2 is never reached.
    last_addr = AW'(1);
    push_walk(4);
    play = 1'b1;
    wait_drain("last_addr_wrap", 150, 1'b0);
    stop_song();
    last_addr = AW'(7);

    // Asynchronous reset in the middle of note 5.
    play = 1'b1;
    wait_valid("reset_lead_in", 4);
    rst_n     = 1'b0;
    flush_req = 1'b1;
    #1;
    chk("async_reset_rom_addr", int'(rom_addr), 0);
    chk("async_reset_note_out", int'(note_out), 0);
    chk("async_reset_note_valid", int'(note_valid), 0);
    chk("async_reset_song_end", int'(song_end), 0);
    repeat (3) @(negedge clk);
    push_walk(3);
    rst_n = 1'b1;
    wait_drain("after_reset", 100, 1'b0);
    stop_song();

    // play drops exactly on the final tick of note 5.
    push_note(5, 8, 1);
    play = 1'b1;
    wait_valid("final_tick_lead_in", 8);
    play = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_tick_note_out", int'(note_out), 9);
    chk("final_tick_note_valid", int'(note_valid), 0);
    chk("final_tick_rom_addr", int'(rom_addr), 1);
    push_note(9, 4, 2);
    push_send();
    play = 1'b1;
    wait_drain("final_tick_resume", 100, 1'b0);
    stop_song();

    // Random songs with random pauses; the first fills the ROM and wraps at 2^AW-1.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        rom_n[i] = NW'($urandom_range(1, 63));
        rom_d[i] = DW'($urandom_range(1, 3));
      end
      if (r == 0) begin
        len       = DEPTH;
        last_addr = AW'(DEPTH - 1);
        push_walk(2 * len + 1);
      end else begin
        len = $urandom_range(1, DEPTH - 1);
        if ($urandom_range(0, 1) == 1) begin
          rom_d[len] = '0;
          last_addr  = AW'(DEPTH - 1);
        end else begin
          last_addr = AW'(len - 1);
        end
        push_walk(2 * (len + 1));
      end
      play = 1'b1;
      wait_drain("random_song", 3000, 1'b1);
      stop_song();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
